// File: rtl/mem_align_pkg.sv
// -----------------------------------------------------------------------------
// mem_align_pkg
//   Shared definitions for the byte-granular alignment paths (read and write
//   side) of the composed line RAMs.
//   - DATA_W_DEF / ADDR_W_DEF : default line width (bits) and line address width
//   - BYTES / OFF_W           : bytes per line and byte-offset width for defaults
//   - clog2()                 : elaboration-time log2, also used by the shifters
//   - rd_state_t              : read-aligner FSM states
// -----------------------------------------------------------------------------
package mem_align_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 19;

  // Ceiling log2 for parameter derivation; returns 1 for v <= 2 so that a
  // derived width is never zero.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  localparam int BYTES = DATA_W_DEF / 8;
  localparam int OFF_W = clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT0 = 2'd1,
    WAIT1 = 2'd2,
    RESP  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/circular_shifter_right_byte_N.sv
// -----------------------------------------------------------------------------
// circular_shifter_right_byte_N
//   Combinational rotate-right of an N-byte word by a whole number of bytes.
//   Output byte i takes input byte (i + shift) mod N, so the byte at index
//   'shift' lands at index 0.
//   Ports:
//     i_data  [N*8-1:0]     word to rotate
//     i_shift [SHIFT_W-1:0] rotate amount in bytes
//     o_data  [N*8-1:0]     rotated word
// -----------------------------------------------------------------------------
module circular_shifter_right_byte_N
  import mem_align_pkg::*;
#(
  parameter int N       = 16,
  parameter int SHIFT_W = clog2(N)
) (
  input  logic [N*8-1:0]     i_data,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [N*8-1:0]     o_data
);

  always_comb begin
    // NOTE: give every always_comb output a full default first; a path that
    // leaves it unassigned would infer a latch.
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      // N is a power of two, so the modulo reduces to dropping carry bits.
      o_data[i*8 +: 8] = i_data[8*((i + int'(i_shift)) % N) +: 8];
    end
  end

endmodule

// File: rtl/unaligned_read_aligner.sv
// -----------------------------------------------------------------------------
// unaligned_read_aligner
//   Accepts one byte-addressed read of 1..LINE_BYTES bytes, reads one or two
//   consecutive RAM lines, rotates and merges them, and returns the requested
//   bytes LSB-aligned and zero-padded.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     req_valid/req_ready   request handshake (ready only in IDLE)
//     req_addr [BADDR_W]    byte address: {line, offset}
//     req_len  [OFFS_W]     byte count minus one
//     ram_rden, ram_addr    RAM read port request (data back one cycle later)
//     ram_q    [DATA_W]     RAM read data
//     rsp_valid/rsp_ready   response handshake
//     rsp_data [DATA_W]     byte i = memory byte (req_addr+i) for i<=len, else 0
// -----------------------------------------------------------------------------
module unaligned_read_aligner
  import mem_align_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int ADDR_W     = ADDR_W_DEF,
  localparam int LINE_BYTES = DATA_W / 8,
  localparam int OFFS_W     = clog2(LINE_BYTES),
  localparam int BADDR_W    = ADDR_W + OFFS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [OFFS_W-1:0]  req_len,
  output logic               ram_rden,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [DATA_W-1:0]  ram_q,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data
);

  rd_state_t           r_state;
  logic [ADDR_W-1:0]   r_line;
  logic [OFFS_W-1:0]   r_off;
  logic [OFFS_W-1:0]   r_len;
  logic                r_cross;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_hi;

  logic [ADDR_W-1:0]   w_req_line;
  logic [OFFS_W-1:0]   w_req_off;
  logic [OFFS_W:0]     w_end;
  logic                w_rden;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_rl;
  logic [DATA_W-1:0]   w_rh;
  logic [DATA_W-1:0]   w_merged;

  assign w_req_line = req_addr[BADDR_W-1:OFFS_W];
  assign w_req_off  = req_addr[OFFS_W-1:0];
  // Last byte index relative to the line start; the extra bit set means the
  // access spills into the next line.
  assign w_end      = {1'b0, w_req_off} + {1'b0, req_len};

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the captured line data is cleared on reset as well, so rsp_data
    // reads zero under reset and no stale line can leak into a later response.
    if (!rst_n) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_off   <= '0;
      r_len   <= '0;
      r_cross <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register sees the
      // pre-edge values of the others regardless of statement order.
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_line  <= w_req_line;
            r_off   <= w_req_off;
            r_len   <= req_len;
            r_cross <= w_end[OFFS_W];
            r_hi    <= '0;
            r_state <= WAIT0;
          end
        end
        WAIT0: begin
          r_lo    <= ram_q;
          r_state <= r_cross ? WAIT1 : RESP;
        end
        WAIT1: begin
          r_hi    <= ram_q;
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM read requests: first line straight from the request at accept, the
  // following line (wrapping past the top) one cycle later for a crossing.
  always_comb begin
    w_rden = 1'b0;
    w_addr = '0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_rden = 1'b1;
          w_addr = w_req_line;
        end
      end
      WAIT0: begin
        if (r_cross) begin
          w_rden = 1'b1;
          w_addr = r_line + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // The accept-cycle request path is combinational from req_valid, so it is
  // gated by rst_n to keep the read port quiet while reset is held.
  assign ram_rden = rst_n & w_rden;
  assign ram_addr = rst_n ? w_addr : '0;

  circular_shifter_right_byte_N #(
    .N       (LINE_BYTES),
    .SHIFT_W (OFFS_W)
  ) u_rot_lo (
    .i_data  (r_lo),
    .i_shift (r_off),
    .o_data  (w_rl)
  );

  circular_shifter_right_byte_N #(
    .N       (LINE_BYTES),
    .SHIFT_W (OFFS_W)
  ) u_rot_hi (
    .i_data  (r_hi),
    .i_shift (r_off),
    .o_data  (w_rh)
  );

  // Bytes that came from the first line occupy indices below
  // LINE_BYTES-offset; the rest came from the second line. Bytes past the
  // requested length are zeroed. Only registered state feeds this, so the
  // output holds steady under back-pressure.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (i > int'(r_len))
        w_merged[i*8 +: 8] = 8'h00;
      else if (i < LINE_BYTES - int'(r_off))
        w_merged[i*8 +: 8] = w_rl[i*8 +: 8];
      else
        w_merged[i*8 +: 8] = w_rh[i*8 +: 8];
    end
  end

  assign rsp_data = w_merged;

endmodule

// File: tb/tb_unaligned_read_aligner.sv
// -----------------------------------------------------------------------------
// tb_unaligned_read_aligner
//   Scoreboard bench: the driver pushes expected RAM line addresses and the
//   expected response (data + latency) when it issues a request; a monitor
//   pops and compares whenever the DUT reads the RAM or completes a response.
//   Reference: memory byte at byte address a is (a & 0xFF), addresses wrap
//   modulo the byte address space; a response is simply bytes a..a+len.
// -----------------------------------------------------------------------------
module tb_unaligned_read_aligner;

  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 19;
  localparam int OFFS_W  = 4;
  localparam int BADDR_W = ADDR_W + OFFS_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                lat;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [BADDR_W-1:0] req_addr;
  logic [OFFS_W-1:0]  req_len;
  logic               ram_rden;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_q;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  bit bp_auto = 1'b1;
  bit prev_valid = 1'b0;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] ram_exp_q[$];

  unaligned_read_aligner #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .ram_rden  (ram_rden),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: line k byte i = (k*16+i) & 0xFF, one cycle read latency.
  function automatic logic [DATA_W-1:0] line_data(input logic [ADDR_W-1:0] k);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'((int'(k) * 16 + i) & 255);
    return d;
  endfunction

  always @(posedge clk) if (ram_rden) ram_q <= line_data(ram_addr);

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference response: bytes addr..addr+len, byte address space wraps.
  function automatic logic [DATA_W-1:0] model_data(input logic [BADDR_W-1:0] a,
                                                   input logic [OFFS_W-1:0] l);
    logic [DATA_W-1:0] d;
    logic [BADDR_W-1:0] b;
    d = '0;
    for (int i = 0; i <= int'(l); i++) begin
      b = a + BADDR_W'(i);
      d[i*8 +: 8] = b[7:0];
    end
    return d;
  endfunction

  // Issue a request, record expectations, wait for accept, then scramble the
  // request inputs (they must not matter after accept).
  task automatic send(input logic [BADDR_W-1:0] a, input logic [OFFS_W-1:0] l);
    exp_t e;
    bit ok;
    int first_line_bytes;
    logic [ADDR_W-1:0] ln;
    first_line_bytes = 16 - int'(a[3:0]);
    ln = a[BADDR_W-1:OFFS_W];
    e.data = model_data(a, l);
    e.lat  = (int'(l) + 1 > first_line_bytes) ? 3 : 2;
    exp_q.push_back(e);
    ram_exp_q.push_back(ln);
    if (e.lat == 3) ram_exp_q.push_back(ln + 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = BADDR_W'($urandom);
    req_len   = OFFS_W'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [BADDR_W-1:0] a, input logic [OFFS_W-1:0] l);
    send(a, l);
    wait_idle();
  endtask

  // Back-pressure driver for rsp_ready.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_auto) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares RAM reads, response latency and response data.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (ram_rden) begin
          if (ram_exp_q.size() == 0) check("unexpected_rden", 1, 0);
          else check("ram_addr", DATA_W'(ram_addr), DATA_W'(ram_exp_q.pop_front()));
        end
        if (req_valid && req_ready) acc_cyc = cyc;
        if (rsp_valid && !prev_valid) begin
          if (exp_q.size() == 0) check("stale_rsp_valid", 1, 0);
          else check("rsp_latency", DATA_W'(cyc - acc_cyc), DATA_W'(exp_q[0].lat));
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0)
          check("rsp_data", rsp_data, exp_q.pop_front().data);
        prev_valid = rsp_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [BADDR_W-1:0] a;
    logic [OFFS_W-1:0]  l;
    logic [DATA_W-1:0]  e;

    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 23'h000020;
    req_len   = 4'd3;
    #3;
    // Reset values, with a request already offered.
    check("reset_req_ready", DATA_W'(req_ready), 1);
    check("reset_ram_rden",  DATA_W'(ram_rden),  0);
    check("reset_ram_addr",  DATA_W'(ram_addr),  0);
    check("reset_rsp_valid", DATA_W'(rsp_valid), 0);
    check("reset_rsp_data",  rsp_data,           0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(23'h000020, 4'd15);   // aligned full line
    issue(23'h000025, 4'd3);    // unaligned, single line
    issue(23'h00002E, 4'd3);    // crossing
    issue(23'h7FFFFF, 4'd1);    // top line wraps to line 0
    issue(23'h000031, 4'd14);   // ends exactly at line boundary (no cross)
    issue(23'h00003F, 4'd15);   // maximum crossing

    // Back-pressure: rsp_ready low for 5 cycles in RESP.
    bp_auto   = 1'b0;
    rsp_ready = 1'b0;
    e = model_data(23'h000137, 4'd12);
    send(23'h000137, 4'd12);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check("bp_rsp_valid", DATA_W'(rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_data",  rsp_data,           e);
      check("bp_req_ready",  DATA_W'(req_ready), 0);
      check("bp_no_rden",    DATA_W'(ram_rden),  0);
      check("bp_hold_valid", DATA_W'(rsp_valid), 1);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_post_req_ready", DATA_W'(req_ready), 1);
    check("bp_post_rsp_valid", DATA_W'(rsp_valid), 0);
    @(posedge clk); #1;
    bp_auto = 1'b1;

    // Reset during WAIT1 of a crossing access.
    send(23'h00012E, 4'd5);      // returns in WAIT0
    @(posedge clk); #2;          // now in WAIT1
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 23'h000040;
    #1;
    check("midrst_req_ready", DATA_W'(req_ready), 1);
    check("midrst_ram_rden",  DATA_W'(ram_rden),  0);
    check("midrst_ram_addr",  DATA_W'(ram_addr),  0);
    check("midrst_rsp_valid", DATA_W'(rsp_valid), 0);
    check("midrst_rsp_data",  rsp_data,           0);
    exp_q.delete();
    ram_exp_q.delete();
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("postrst_req_ready", DATA_W'(req_ready), 1);
    end
    @(posedge clk); #1;
    issue(23'h00005A, 4'd9);

    // Randomized traffic, biased toward high offsets and the top line.
    for (int n = 0; n < 150; n++) begin
      a = BADDR_W'($urandom);
      if ($urandom_range(0, 3) == 0) a[3:0] = 4'(12 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a[BADDR_W-1:OFFS_W] = '1;
      l = OFFS_W'($urandom);
      issue(a, l);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained",     DATA_W'(exp_q.size()),     0);
    check("ram_exp_q_drained", DATA_W'(ram_exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
